// File: rtl/run_pkg.sv
// Shared types and helpers for the run-length pattern transmitter and its trackers.
package run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int RUN_LEN_DEFAULT = 4;

  function automatic int run_cnt_w(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/run_tracker.sv
// Tracks the length of the current run of equal bits, saturating at RUN_LEN.
module run_tracker
  import run_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          advance,
  input  logic                          bit_in,
  output logic [run_cnt_w(RUN_LEN)-1:0] run_cnt,
  output logic                          z_expect
);

  localparam int RW = run_cnt_w(RUN_LEN);

  logic [RW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (clear) begin
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (advance) begin
      last_d = bit_in;
      // A zero count means no bit has been seen yet in this word.
      if (cnt_q == '0 || bit_in != last_q)
        cnt_d = RW'(1);
      else if (cnt_q != RW'(RUN_LEN))
        cnt_d = cnt_q + RW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign run_cnt  = cnt_q;
  assign z_expect = (cnt_q == RW'(RUN_LEN));

endmodule

// File: rtl/run_pattern_tx.sv
// Serial pattern transmitter: loads a word, shifts it out MSB first on step,
// and reports the run-length detection the receiver must raise per bit.
module run_pattern_tx
  import run_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int RUN_LEN = RUN_LEN_DEFAULT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [WIDTH-1:0]              pattern,
  input  logic                          step,
  output logic                          w_out,
  output logic                          w_valid,
  output logic                          z_expect,
  output logic [run_cnt_w(RUN_LEN)-1:0] run_cnt,
  output logic                          done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             trk_clr, trk_adv, trk_bit, trk_z;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    w_valid    = 1'b0;
    done       = 1'b0;
    trk_clr    = 1'b0;
    trk_adv    = 1'b0;
    trk_bit    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          sr_d    = pattern;
          cnt_d   = CW'(WIDTH - 1);
          state_d = ST_SHIFT;
          trk_adv = 1'b1;
          trk_bit = pattern[WIDTH-1];
        end else begin
          trk_clr = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_valid = 1'b1;
        if (step) begin
          if (cnt_q != '0) begin
            sr_d    = {sr_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CW'(1);
            trk_adv = 1'b1;
            trk_bit = sr_q[WIDTH-2];
          end else begin
            // Clear the tracker on the way out so DONE already shows zero.
            state_d = ST_DONE;
            trk_clr = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        trk_clr = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        trk_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  run_tracker #(.RUN_LEN(RUN_LEN)) u_trk (
    .clock    (clock),
    .reset    (reset),
    .clear    (trk_clr),
    .advance  (trk_adv),
    .bit_in   (trk_bit),
    .run_cnt  (run_cnt),
    .z_expect (trk_z)
  );

  assign w_out    = w_valid & sr_q[WIDTH-1];
  assign z_expect = w_valid & trk_z;

endmodule

// File: tb/tb_run_pattern_tx.sv
// Bench for run_pattern_tx: directed and random words against a per-bit run model.
module tb_run_pattern_tx;

  localparam int W = 16;
  localparam int R = 4;

  logic          clk = 1'b0;
  logic          reset, load_valid, step;
  logic [W-1:0]  pattern;
  logic          load_ready, w_out, w_valid, z_expect, done;
  logic [2:0]    run_cnt;

  int checks = 0;
  int errors = 0;
  bit cl_en  = 1'b0;

  always #5 clk = ~clk;

  run_pattern_tx #(.WIDTH(W), .RUN_LEN(R)) dut (
    .clock(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .pattern(pattern), .step(step), .w_out(w_out), .w_valid(w_valid),
    .z_expect(z_expect), .run_cnt(run_cnt), .done(done)
  );

  // Receiving 4-in-a-row detector sampled on step cycles, plus z_expect delayed one step.
  logic [2:0] det_run;
  logic       det_last, det_z, zexp_dly;
  always @(posedge clk) begin
    if (reset || done) begin
      det_run <= 0; det_last <= 0; det_z <= 0; zexp_dly <= 0;
    end else if (step && w_valid) begin
      det_last <= w_out;
      zexp_dly <= z_expect;
      if (det_run != 0 && w_out == det_last) begin
        det_run <= (det_run >= 3'(R)) ? 3'(R) : det_run + 3'd1;
        det_z   <= (det_run >= 3'(R - 1));
      end else begin
        det_run <= 3'd1;
        det_z   <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Length of the equal-bit run ending at bit index idx (0 = MSB), capped at R.
  function automatic int run_len(input logic [W-1:0] w, input int idx);
    int n = 1;
    for (int j = idx - 1; j >= 0; j--) begin
      if (w[W-1-j] != w[W-1-idx]) break;
      n++;
    end
    return (n > R) ? R : n;
  endfunction

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_word(input logic [W-1:0] w, input int step_pct, input bit hold_valid,
                          input int stall_idx, input int stall_len);
    int idx = 0, guard = 0, stalls = stall_len;
    bit st;
    chk("idle_ready", load_ready, 1);
    load_valid = 1; pattern = w; step = 0;
    @(negedge clk);
    if (!hold_valid) load_valid = 0;
    while (idx < W) begin
      chk("w_valid", w_valid, 1);
      chk("w_out", w_out, w[W-1-idx]);
      chk("run_cnt", run_cnt, run_len(w, idx));
      chk("z_expect", z_expect, run_len(w, idx) == R);
      chk("ready_shift", load_ready, 0);
      chk("done_shift", done, 0);
      if (cl_en && idx >= 1) chk("det_align", det_z, zexp_dly);
      if (idx == stall_idx && stalls > 0) begin st = 0; stalls--; end
      else st = ($urandom_range(0, 99) < step_pct);
      step = st;
      @(negedge clk);
      if (st) idx++;
      if (++guard > 400) begin chk("shift_timeout", idx, W); break; end
    end
    step = $urandom_range(0, 1);
    chk("done_pulse", done, 1);
    chk("done_wvalid", w_valid, 0);
    chk("done_ready", load_ready, 0);
    chk("done_runcnt", run_cnt, 0);
    chk("done_z", z_expect, 0);
    @(negedge clk);
    step = 0;
    chk("idle_done", done, 0);
    chk("idle_ready2", load_ready, 1);
    chk("idle_wvalid", w_valid, 0);
  endtask

  initial begin
    reset = 1; load_valid = 0; step = 0; pattern = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", load_ready, 1);
    chk("rst_wvalid", w_valid, 0);
    chk("rst_wout", w_out, 0);
    chk("rst_runcnt", run_cnt, 0);
    chk("rst_z", z_expect, 0);
    chk("rst_done", done, 0);
    reset = 0;
    @(negedge clk);

    // Reset mid-SHIFT discards the word.
    load_valid = 1; pattern = 16'hFFFF;
    @(negedge clk);
    load_valid = 0; step = 1;
    repeat (5) @(negedge clk);
    chk("mid_runcnt_pre", run_cnt, R);
    step = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_wvalid", w_valid, 0);
    chk("mid_runcnt", run_cnt, 0);
    chk("mid_ready", load_ready, 1);
    chk("mid_done", done, 0);
    @(negedge clk);
    chk("mid_done2", done, 0);

    run_word(16'hF00F, 100, 0, -1, 0);
    run_word(16'hAAAA, 100, 0, -1, 0);
    run_word(16'h000F, 100, 0, 2, 3);

    // Held load_valid: one capture per word, recapture only in the IDLE after done.
    run_word(16'h1234, 100, 1, -1, 0);
    run_word(16'h1234, 70, 1, -1, 0);
    load_valid = 0;
    @(negedge clk);

    cl_en = 1;
    run_word(16'h00FF, 100, 0, -1, 0);
    for (int k = 0; k < 6; k++) run_word(16'($urandom), 60, 0, -1, 0);
    cl_en = 0;

    for (int k = 0; k < 6; k++) run_word(16'($urandom), $urandom_range(30, 100), 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
